// File: rtl/uart_bridge_pkg.sv
// Shared types and constants for the UART-AXI bridge transmit path.
package uart_bridge_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PASS = 1'b1
  } arb_state_e;

  localparam int BYTE_W              = 8;
  localparam int MAX_REQ             = 8;
  localparam int DEFAULT_TIMEOUT_CYC = 1024;

  typedef logic [$clog2(MAX_REQ)-1:0] req_idx_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first asserted request at or above ptr, wrapping.
module rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] winner,
  output logic             any_req
);

  int idx;

  // Walk the requests from ptr upward and keep the first hit.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!any_req && req[idx]) begin
        winner  = IDX_W'(idx);
        any_req = 1'b1;
      end else begin
        winner  = winner;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one UART TX serializer among NUM_REQ
// byte streams, with a watchdog that releases a stalled owner.
module uart_tx_arbiter
  import uart_bridge_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int DATA_W      = BYTE_W,
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_valid,
  output logic [DATA_W-1:0]          tx_data,
  input  logic                       tx_ready,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       timeout_err,
  output logic [$clog2(NUM_REQ)-1:0] timeout_src
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  arb_state_e       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] next_ptr;
  logic [IDX_W-1:0] winner;
  logic             any_req;
  logic [CNT_W-1:0] wd_cnt;
  logic             cur_valid;
  logic             cur_last;
  logic             hs;

  rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  assign cur_valid = req_valid[grant_id];
  assign cur_last  = req_last[grant_id];
  assign hs        = (state == PASS) && cur_valid && tx_ready;
  assign next_ptr  = (grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id + IDX_W'(1);

  // Owner's stream is passed straight through while a packet is granted.
  always_comb begin
    req_ready = '0;
    tx_valid  = 1'b0;
    tx_data   = '0;
    if (state == PASS) begin
      tx_valid            = cur_valid;
      tx_data             = req_data[int'(grant_id)*DATA_W +: DATA_W];
      req_ready[grant_id] = tx_ready;
    end else begin
      tx_valid = 1'b0;
    end
  end

  // Grant FSM, round-robin pointer and watchdog.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant_id    <= '0;
      wd_cnt      <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      timeout_src <= '0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_id <= winner;
            wd_cnt   <= '0;
            busy     <= 1'b1;
            state    <= PASS;
          end else begin
            state <= IDLE;
          end
        end
        PASS: begin
          if (hs) begin
            wd_cnt <= '0;
            if (cur_last) begin
              rr_ptr <= next_ptr;
              busy   <= 1'b0;
              state  <= IDLE;
            end else begin
              state <= PASS;
            end
          end else if (!cur_valid) begin
            // Release on the cycle the count would reach TIMEOUT_CYC.
            if (wd_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
              wd_cnt      <= CNT_W'(TIMEOUT_CYC);
              rr_ptr      <= next_ptr;
              busy        <= 1'b0;
              timeout_err <= 1'b1;
              timeout_src <= grant_id;
              state       <= IDLE;
            end else if (wd_cnt != CNT_W'(TIMEOUT_CYC)) begin
              wd_cnt <= wd_cnt + CNT_W'(1);
            end else begin
              wd_cnt <= wd_cnt;
            end
          end else begin
            wd_cnt <= wd_cnt;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with two requesters and a 4-cycle watchdog.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_last;
  logic [1:0]  req_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic [0:0]  grant_id;
  logic        busy;
  logic        timeout_err;
  logic [0:0]  timeout_src;
  logic [13:0] obs;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(2), .DATA_W(8), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_valid(tx_valid),
    .tx_data(tx_data), .tx_ready(tx_ready), .grant_id(grant_id), .busy(busy),
    .timeout_err(timeout_err), .timeout_src(timeout_src)
  );

  // {busy, tx_valid, tx_data, grant_id, req_ready, timeout_err}
  assign obs = {busy, tx_valid, tx_data, grant_id, req_ready, timeout_err};

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic v, input logic [7:0] d, input logic l);
    req_valid[r]     = v;
    req_data[r*8 +: 8] = d;
    req_last[r]      = l;
  endtask

  task automatic do_reset;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tx_ready  = 1'b1;
    rst       = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    @(negedge clk);
    if (obs !== 14'b0) begin
      $display("FAIL reset_state: got %h expected %h", obs, 14'b0); n_err++;
    end
    n_vec++;
    if (timeout_src !== 1'b0) begin
      $display("FAIL reset_src: got %h expected 0", timeout_src); n_err++;
    end
    n_vec++;
  endtask

  task automatic test_single_packet;
    logic [7:0] bytes [3];
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
    do_reset();
    set_req(0, 1'b1, bytes[0], 1'b0);
    @(negedge clk);
    if (obs !== {1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0}) begin
      $display("FAIL single_idle: got %h expected %h", obs, {1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0}); n_err++;
    end
    n_vec++;
    cyc();
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      if (obs !== {1'b1, 1'b1, bytes[b], 1'b0, 2'b01, 1'b0}) begin
        $display("FAIL single_byte%0d: got %h expected %h", b, obs, {1'b1, 1'b1, bytes[b], 1'b0, 2'b01, 1'b0}); n_err++;
      end
      n_vec++;
      cyc();
      if (b < 2) set_req(0, 1'b1, bytes[b+1], (b == 1) ? 1'b1 : 1'b0);
      else       set_req(0, 1'b0, 8'h00, 1'b0);
    end
    @(negedge clk);
    if (obs !== {1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0}) begin
      $display("FAIL single_end: got %h expected %h", obs, {1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0}); n_err++;
    end
    n_vec++;
  endtask

  task automatic test_round_robin;
    logic [7:0] d;
    do_reset();
    for (int rnd = 0; rnd < 2; rnd++) begin
      set_req(0, 1'b1, 8'h40 + 8'(rnd*4), 1'b0);
      set_req(1, 1'b1, 8'h50 + 8'(rnd*4), 1'b0);
      // Both requesters contend each round; order must be 0 then 1 each time.
      for (int p = 0; p < 2; p++) begin
        @(negedge clk);
        if (tx_valid !== 1'b0 || busy !== 1'b0) begin
          $display("FAIL rr_bubble r%0d p%0d: got valid=%b busy=%b expected 0 0", rnd, p, tx_valid, busy); n_err++;
        end
        n_vec++;
        cyc();
        for (int b = 0; b < 2; b++) begin
          d = 8'h40 + 8'(p*16) + 8'(rnd*4) + 8'(b);
          @(negedge clk);
          if (obs !== {1'b1, 1'b1, d, 1'(p), (p == 0) ? 2'b01 : 2'b10, 1'b0}) begin
            $display("FAIL rr_r%0d_p%0d_b%0d: got %h expected %h", rnd, p, b, obs,
                     {1'b1, 1'b1, d, 1'(p), (p == 0) ? 2'b01 : 2'b10, 1'b0}); n_err++;
          end
          n_vec++;
          cyc();
          if (b == 0) set_req(p, 1'b1, d + 8'h01, 1'b1);
          else        set_req(p, 1'b0, 8'h00, 1'b0);
        end
      end
    end
  endtask

  task automatic test_backpressure;
    do_reset();
    set_req(0, 1'b1, 8'hC0, 1'b0);
    cyc();
    cyc();
    set_req(0, 1'b1, 8'hC1, 1'b0);
    tx_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      if (obs !== {1'b1, 1'b1, 8'hC1, 1'b0, 2'b00, 1'b0}) begin
        $display("FAIL stall_%0d: got %h expected %h", s, obs, {1'b1, 1'b1, 8'hC1, 1'b0, 2'b00, 1'b0}); n_err++;
      end
      n_vec++;
      cyc();
    end
    tx_ready = 1'b1;
    @(negedge clk);
    if (obs !== {1'b1, 1'b1, 8'hC1, 1'b0, 2'b01, 1'b0}) begin
      $display("FAIL stall_release: got %h expected %h", obs, {1'b1, 1'b1, 8'hC1, 1'b0, 2'b01, 1'b0}); n_err++;
    end
    n_vec++;
    cyc();
    set_req(0, 1'b1, 8'hC2, 1'b1);
    @(negedge clk);
    if (obs !== {1'b1, 1'b1, 8'hC2, 1'b0, 2'b01, 1'b0}) begin
      $display("FAIL stall_last: got %h expected %h", obs, {1'b1, 1'b1, 8'hC2, 1'b0, 2'b01, 1'b0}); n_err++;
    end
    n_vec++;
    cyc();
    set_req(0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_timeout;
    do_reset();
    set_req(1, 1'b1, 8'hD0, 1'b0);
    cyc();
    @(negedge clk);
    if (obs !== {1'b1, 1'b1, 8'hD0, 1'b1, 2'b10, 1'b0}) begin
      $display("FAIL wd_first: got %h expected %h", obs, {1'b1, 1'b1, 8'hD0, 1'b1, 2'b10, 1'b0}); n_err++;
    end
    n_vec++;
    cyc();
    set_req(1, 1'b0, 8'h00, 1'b0);
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      if (obs !== {1'b1, 1'b0, 8'h00, 1'b1, 2'b10, 1'b0}) begin
        $display("FAIL wd_wait_%0d: got %h expected %h", s, obs, {1'b1, 1'b0, 8'h00, 1'b1, 2'b10, 1'b0}); n_err++;
      end
      n_vec++;
      cyc();
    end
    @(negedge clk);
    if (obs !== {1'b0, 1'b0, 8'h00, 1'b1, 2'b00, 1'b1} || timeout_src !== 1'b1) begin
      $display("FAIL wd_pulse: got %h src %h expected %h src 1", obs, timeout_src,
               {1'b0, 1'b0, 8'h00, 1'b1, 2'b00, 1'b1}); n_err++;
    end
    n_vec++;
    set_req(0, 1'b1, 8'h51, 1'b1);
    set_req(1, 1'b1, 8'h61, 1'b1);
    cyc();
    @(negedge clk);
    if (obs !== {1'b1, 1'b1, 8'h51, 1'b0, 2'b01, 1'b0}) begin
      $display("FAIL wd_next_req0: got %h expected %h", obs, {1'b1, 1'b1, 8'h51, 1'b0, 2'b01, 1'b0}); n_err++;
    end
    n_vec++;
    cyc();
    set_req(0, 1'b0, 8'h00, 1'b0);
    cyc();
    @(negedge clk);
    if (obs !== {1'b1, 1'b1, 8'h61, 1'b1, 2'b10, 1'b0}) begin
      $display("FAIL wd_then_req1: got %h expected %h", obs, {1'b1, 1'b1, 8'h61, 1'b1, 2'b10, 1'b0}); n_err++;
    end
    n_vec++;
    cyc();
    set_req(1, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_mid_reset;
    do_reset();
    set_req(0, 1'b1, 8'h71, 1'b1);
    cyc();
    cyc();
    set_req(0, 1'b0, 8'h00, 1'b0);
    set_req(1, 1'b1, 8'h81, 1'b0);
    cyc();
    @(negedge clk);
    if (obs !== {1'b1, 1'b1, 8'h81, 1'b1, 2'b10, 1'b0}) begin
      $display("FAIL rst_pre: got %h expected %h", obs, {1'b1, 1'b1, 8'h81, 1'b1, 2'b10, 1'b0}); n_err++;
    end
    n_vec++;
    cyc();
    set_req(1, 1'b1, 8'h82, 1'b1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    set_req(0, 1'b1, 8'h91, 1'b1);
    @(negedge clk);
    if (obs !== {1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0}) begin
      $display("FAIL rst_after: got %h expected %h", obs, {1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0}); n_err++;
    end
    n_vec++;
    cyc();
    @(negedge clk);
    if (obs !== {1'b1, 1'b1, 8'h91, 1'b0, 2'b01, 1'b0}) begin
      $display("FAIL rst_rr_from0: got %h expected %h", obs, {1'b1, 1'b1, 8'h91, 1'b0, 2'b01, 1'b0}); n_err++;
    end
    n_vec++;
    cyc();
    set_req(0, 1'b0, 8'h00, 1'b0);
    cyc();
    @(negedge clk);
    if (obs !== {1'b1, 1'b1, 8'h82, 1'b1, 2'b10, 1'b0}) begin
      $display("FAIL rst_req1_kept: got %h expected %h", obs, {1'b1, 1'b1, 8'h82, 1'b1, 2'b10, 1'b0}); n_err++;
    end
    n_vec++;
    cyc();
    set_req(1, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_back_to_back;
    do_reset();
    set_req(1, 1'b1, 8'hA1, 1'b1);
    cyc();
    set_req(0, 1'b1, 8'hB0, 1'b1);
    @(negedge clk);
    if (obs !== {1'b1, 1'b1, 8'hA1, 1'b1, 2'b10, 1'b0}) begin
      $display("FAIL b2b_req1: got %h expected %h", obs, {1'b1, 1'b1, 8'hA1, 1'b1, 2'b10, 1'b0}); n_err++;
    end
    n_vec++;
    cyc();
    set_req(1, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    if (obs !== {1'b0, 1'b0, 8'h00, 1'b1, 2'b00, 1'b0}) begin
      $display("FAIL b2b_bubble: got %h expected %h", obs, {1'b0, 1'b0, 8'h00, 1'b1, 2'b00, 1'b0}); n_err++;
    end
    n_vec++;
    cyc();
    @(negedge clk);
    if (obs !== {1'b1, 1'b1, 8'hB0, 1'b0, 2'b01, 1'b0}) begin
      $display("FAIL b2b_req0: got %h expected %h", obs, {1'b1, 1'b1, 8'hB0, 1'b0, 2'b01, 1'b0}); n_err++;
    end
    n_vec++;
    cyc();
    set_req(0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    if (obs !== {1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0}) begin
      $display("FAIL b2b_end: got %h expected %h", obs, {1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0}); n_err++;
    end
    n_vec++;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tx_ready  = 1'b1;
    test_reset();
    test_single_packet();
    test_round_robin();
    test_backpressure();
    test_timeout();
    test_mid_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART transmit serializer of the UART-AXI bridge between NUM_REQ byte-stream requesters, for example the AXI read-response formatter and the status/interrupt reporter.
- Grants the serializer packet by packet, using round-robin priority.
- A granted requester holds the serializer until its last byte is accepted.
- A watchdog releases the grant if the granted requester stalls mid-packet.
- Sits between the bridge framers and the UART TX shift register that drives txd.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
DATA_W, 8, byte width on every stream
TIMEOUT_CYC, 1024, consecutive mid-packet cycles with the granted req_valid low before forced release (>=2)

Ports:
clk  input  1  system clock; single clock domain
rst  input  1  synchronous, active-high reset
req_valid  input  NUM_REQ  per-requester byte valid
req_data  input  NUM_REQ*DATA_W  per-requester byte; requester i occupies bits [i*DATA_W +: DATA_W]
req_last  input  NUM_REQ  marks the final byte of a packet
req_ready  output  NUM_REQ  per-requester accept
tx_valid  output  1  byte valid to the UART serializer
tx_data  output  DATA_W  byte to the serializer
tx_ready  input  1  serializer accepts the byte
grant_id  output  $clog2(NUM_REQ)  index of the current owner; held at the last owner while IDLE
busy  output  1  high while a packet is granted
timeout_err  output  1  one-cycle pulse on forced release
timeout_src  output  $clog2(NUM_REQ)  requester released by the watchdog; valid while timeout_err is high

Behaviour:
- Reset (synchronous, active-high): on the clock edge with rst=1, all outputs and state are cleared.
  - State = IDLE, rr_ptr = 0, grant_id = 0, timeout counter = 0.
  - busy = 0, timeout_err = 0, timeout_src = 0.
  - tx_valid = 0 and req_ready = 0 from the first cycle after that edge.
  - A packet in flight is abandoned; no byte is emitted after reset.
- States: IDLE, PASS.
- IDLE:
  - tx_valid = 0, req_ready = 0.
  - If any req_valid is high, pick the first asserted index searching upward from rr_ptr, with wrap-around.
  - Register the winner in grant_id and go to PASS next cycle.
  - Grant latency is one cycle from req_valid to the first possible tx_valid.
- PASS, with g = grant_id:
  - tx_valid = req_valid[g], tx_data = req_data[g] (combinational pass-through).
  - req_ready[g] = tx_ready; all other req_ready bits = 0.
  - A handshake is req_valid[g] & tx_ready.
  - Handshake with req_last[g]=1: go to IDLE and set rr_ptr = (g+1) mod NUM_REQ.
  - There is exactly one IDLE bubble cycle between packets.
- Single-byte packet (valid and last on the first byte) is legal: PASS lasts one cycle if tx_ready is high.
- Requester protocol: once req_valid[g] is asserted it must hold, with stable data and last, until the handshake. The arbiter never drops tx_valid without a handshake.
- Watchdog:
  - The counter increments each PASS cycle with req_valid[g]=0.
  - It clears on any handshake and on entry to PASS.
  - Cycles where tx_valid=1 and tx_ready=0 do not count, because the serializer is allowed to stall.
  - When the counter reaches TIMEOUT_CYC:
    - go to IDLE and set rr_ptr = g+1;
    - timeout_err = 1 for one cycle;
    - timeout_src = g.
  - The remainder of that packet is not forwarded.
- Simultaneous requests in IDLE: round-robin decides. Requests from non-owners during PASS wait; they are not lost as long as the requester keeps valid high.
- rr_ptr wraps from NUM_REQ-1 to 0.
- Counter width is $clog2(TIMEOUT_CYC+1) and saturates; it never wraps.
- busy = (state == PASS), registered.

Decomposition:
- Package uart_bridge_pkg holds:
  - typedef arb_state_e {IDLE, PASS};
  - localparam BYTE_W = 8;
  - typedef for the requester index;
  - default TIMEOUT_CYC.
- One sub-module, rr_pick: combinational round-robin priority selector.
  - Inputs: request vector, rr_ptr.
  - Outputs: winner index, any_req.
  - Reusable by the AXI-side response arbiter.

Test Plan:
1. Single requester, 3-byte packet 0x11,0x22,0x33 (last on 0x33), tx_ready=1: tx_valid rises one cycle after req_valid; the three bytes appear in order on consecutive cycles; busy drops the cycle after 0x33.
2. Req0 and req1 both valid in IDLE after reset, 2-byte packets each: req0 is served first, then one bubble, then req1. Repeat with both valid: req0 is served again, because rr_ptr wrapped to 0 after req1.
3. Serializer backpressure: tx_ready low for 5 cycles mid-packet while req_valid[g] is held: tx_data stays stable, no byte is lost, timeout_err stays 0.
4. Granted req1 drops req_valid after byte 1, TIMEOUT_CYC=4: timeout_err pulses exactly 4 cycles later with timeout_src=1; next grant goes to req0, or to req1 if it is the only requester.
5. Assert rst for one cycle mid-packet: tx_valid=0, busy=0, grant_id=0 the following cycle; a new packet afterwards arbitrates from rr_ptr=0.
6. Single-byte packet with last=1 on req1, back-to-back with a 1-byte packet on req0: each PASS lasts one cycle, with one IDLE cycle between them.
